// File: rtl/pq_branch_resolver_pkg.sv
// Shared core definitions for the execute-stage branch resolver: funct3 branch codes
// and the BHT PC-index width derivation.
package pq_branch_resolver_pkg;

  typedef enum logic [2:0] {
    F3Beq  = 3'b000,
    F3Bne  = 3'b001,
    F3Blt  = 3'b100,
    F3Bge  = 3'b101,
    F3Bltu = 3'b110,
    F3Bgeu = 3'b111
  } br_funct3_e;

  // The BHT is indexed with two extra low PC bits beyond BHT_IDW.
  localparam int unsigned BpcIdxExtra = 2;

  function automatic int unsigned calc_bpcw(input int unsigned bht_idw);
    return bht_idw + BpcIdxExtra;
  endfunction

endpackage

// File: rtl/pq_branch_resolver_cmp.sv
// Combinational branch condition evaluation (module pq_branch_cmp); flags funct3 codes
// that are not legal conditional branches.
module pq_branch_cmp
  import pq_branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            legal_o
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    case (funct3_i)
      F3Beq:   taken_o = eq;
      F3Bne:   taken_o = ~eq;
      F3Blt:   taken_o = lt_s;
      F3Bge:   taken_o = ~lt_s;
      F3Bltu:  taken_o = lt_u;
      F3Bgeu:  taken_o = ~lt_u;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pq_branch_resolver.sv
// Execute-stage branch resolver: resolves conditional branches, issues registered predictor
// update strobes and mispredict redirects. Define BPRED_PERF_CNT_EN for perf counters.
module pq_branch_resolver
  import pq_branch_resolver_pkg::*;
#(
  parameter int unsigned  XLEN    = 32,
  parameter int unsigned  GHRW    = 8,
  parameter int unsigned  BHT_IDW = 8,
  localparam int unsigned BPCW    = calc_bpcw(BHT_IDW)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic            i_ext_flush,
  input  logic            i_is_branch,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_immB,
  input  logic            i_pred_btaken,
  input  logic [GHRW-1:0] i_ghr_snapshot,
  output logic            o_upd_ghr,
  output logic            o_upd_bht,
  output logic [BPCW-1:0] o_upd_idx_pc,
  output logic [GHRW-1:0] o_upd_idx_ghr,
  output logic            o_actual_btaken,
  output logic            o_mispredict,
`ifdef BPRED_PERF_CNT_EN
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mispred_cnt,
`endif
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic cmp_taken, cmp_legal, accept;

  logic            upd_q, upd_d;
  logic            mispredict_q, mispredict_d;
  logic            actual_q, actual_d;
  logic [BPCW-1:0] idx_pc_q, idx_pc_d;
  logic [GHRW-1:0] idx_ghr_q, idx_ghr_d;
  logic [XLEN-1:0] redirect_q, redirect_d;

  pq_branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .funct3_i (i_funct3),
    .rs1_i    (i_rs1),
    .rs2_i    (i_rs2),
    .taken_o  (cmp_taken),
    .legal_o  (cmp_legal)
  );

  // The instruction behind a mispredict is on the wrong path, so it is squashed here.
  assign accept = i_valid & i_is_branch & ~i_stall & ~i_ext_flush & ~mispredict_q & cmp_legal;

  always_comb begin
    upd_d        = accept;
    mispredict_d = accept & (cmp_taken != i_pred_btaken);
    actual_d     = actual_q;
    idx_pc_d     = idx_pc_q;
    idx_ghr_d    = idx_ghr_q;
    redirect_d   = redirect_q;
    if (accept) begin
      actual_d   = cmp_taken;
      idx_pc_d   = i_pc[BPCW-1:0];
      idx_ghr_d  = i_ghr_snapshot;
      redirect_d = cmp_taken ? (i_pc + i_immB) : (i_pc + PcStep);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      upd_q        <= 1'b0;
      mispredict_q <= 1'b0;
      actual_q     <= 1'b0;
      idx_pc_q     <= '0;
      idx_ghr_q    <= '0;
      redirect_q   <= '0;
    end else begin
      upd_q        <= upd_d;
      mispredict_q <= mispredict_d;
      actual_q     <= actual_d;
      idx_pc_q     <= idx_pc_d;
      idx_ghr_q    <= idx_ghr_d;
      redirect_q   <= redirect_d;
    end
  end

  assign o_upd_ghr       = upd_q;
  assign o_upd_bht       = upd_q;
  assign o_mispredict    = mispredict_q;
  assign o_actual_btaken = actual_q;
  assign o_upd_idx_pc    = idx_pc_q;
  assign o_upd_idx_ghr   = idx_ghr_q;
  assign o_redirect_pc   = redirect_q;

`ifdef BPRED_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Counters advance alongside the strobe registers so the new count shows in the strobe cycle.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_d && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict_d && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: doc/pq_branch_resolver.md
PQ_BRANCH_RESOLVER -- requirements
Module: pq_branch_resolver

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter GHRW, default 8, global history register width.
REQ-003 SHALL have parameter BHT_IDW, default 8, BHT index width; derived BPCW = BHT_IDW+2.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  execute-stage instruction valid.
- i_stall  in  1  pipeline stall; no acceptance while high.
- i_ext_flush  in  1  external flush (exception/trap) squashing the current instruction.
- i_is_branch  in  1  conditional branch.
- i_funct3  in  3  branch condition code.
- i_rs1, i_rs2  in  XLEN  operand values.
- i_pc  in  XLEN  branch PC.
- i_immB  in  XLEN  sign-extended branch immediate.
- i_pred_btaken  in  1  predicted outcome carried from fetch.
- i_ghr_snapshot  in  GHRW  GHR used at prediction.
- o_upd_ghr, o_upd_bht  out  1  predictor update strobes.
- o_upd_idx_pc  out  BPCW  PC low bits for BHT index.
- o_upd_idx_ghr  out  GHRW  GHR snapshot for BHT index.
- o_actual_btaken  out  1  resolved outcome.
- o_mispredict  out  1  redirect/flush strobe.
- o_redirect_pc  out  XLEN  correct next PC.

Function
REQ-005 SHALL accept a branch when i_valid & i_is_branch & ~i_stall & ~i_ext_flush & ~o_mispredict.
REQ-006 SHALL evaluate the condition by i_funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
REQ-007 SHALL treat funct3 010/011 as illegal: no update strobes, no mispredict.
REQ-008 SHALL register all outputs, with exactly 1 cycle of latency from acceptance to the strobes.
REQ-009 SHALL pulse o_upd_ghr and o_upd_bht for exactly one cycle per accepted legal branch.
REQ-010 SHALL, while the update strobes are high, hold o_upd_idx_pc = i_pc[BPCW-1:0], o_upd_idx_ghr = i_ghr_snapshot and o_actual_btaken = the resolved outcome.
REQ-011 SHALL pulse o_mispredict for one cycle when the resolved outcome differs from i_pred_btaken.
REQ-012 SHALL set o_redirect_pc = i_pc + i_immB if the branch is taken and i_pc + 4 otherwise, using XLEN-bit modulo arithmetic that wraps at 2^XLEN.
REQ-013 SHALL squash any instruction presented in the cycle o_mispredict is high; the next cycle always deasserts o_mispredict.
REQ-014 SHALL drop strobes from a non-accepted cycle; i_stall SHALL NOT stretch pulses.
REQ-015 SHALL hold o_redirect_pc, o_upd_idx_* and o_actual_btaken at their last values when no strobe is active.
REQ-016 SHALL give i_ext_flush priority over a coincident branch; that branch produces no update and no mispredict.

Reset
REQ-017 SHALL drive all outputs and internal registers to 0 on reset.
REQ-018 SHALL abort an in-flight strobe immediately when reset asserts mid-operation, with no pulse after release.
REQ-019 SHALL clear the performance counters on reset when they are present.

Configuration
REQ-020 SHALL, when macro BPRED_PERF_CNT_EN is defined, add 32-bit saturating counters o_br_cnt (accepted legal branches) and o_mispred_cnt (mispredicts), both outputs, updated in the strobe cycle.
REQ-021 SHALL omit the counters, their ports and their logic when BPRED_PERF_CNT_EN is undefined, with all other behaviour identical.

Structure
REQ-022 SHALL place the funct3 branch-code constants and the BPCW derivation in the shared core package.
REQ-023 SHALL implement the condition evaluation as sub-module pq_branch_cmp (combinational), instanced once.

Verification
REQ-024 SHALL cover: BEQ with rs1=rs2=5, pred=0, pc=0x100, immB=0x20 -> next cycle upd strobes=1, actual=1, mispredict=1, redirect=0x120.
REQ-025 SHALL cover: BLTU with rs1=0xFFFFFFFF, rs2=1, pred=0 -> actual=0, no mispredict, redirect=pc+4.
REQ-026 SHALL cover: BLT with rs1=0xFFFFFFFF, rs2=1, pred=1 -> actual=1, no mispredict.
REQ-027 SHALL cover: a mispredicting branch followed back-to-back by a second branch -> second squashed, exactly one strobe pair.
REQ-028 SHALL cover: i_stall=1 with a valid branch for 3 cycles -> no strobes; strobes appear one cycle after the stall drops.
REQ-029 SHALL cover: pc=0xFFFFFFFC, BNE taken with immB=8 -> redirect=0x00000004; reset asserted next cycle -> all outputs 0.
